// File: rtl/distance_bus_pkg.sv
// Shared register map and poll FSM encoding for the ultrasonic distance bridge.
// The responder and this initiator both import these definitions.
package distance_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] DISTANCE = 16'h0900;
  localparam logic [ADDR_W-1:0] BROKEN   = 16'h0904;
  localparam logic [ADDR_W-1:0] STATUS   = 16'h0908;
  localparam logic [ADDR_W-1:0] CAR      = 16'h090C;

  localparam int unsigned STATUS_VALID_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    RD_STAT,
    RD_DIST,
    EVAL,
    WAIT
  } poll_state_t;

endpackage

// File: rtl/car_hysteresis_filter.sv
// Debounced car-present flag: CONFIRM consecutive near/far samples set/clear it,
// samples inside the release band reset both streaks and hold the flag.
module car_hysteresis_filter #(
  parameter logic [15:0] CAR_THRESH = 16'd200,
  parameter logic [15:0] HYST       = 16'd20,
  parameter int unsigned CONFIRM    = 3
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] sample,
  input  logic        sample_en,
  input  logic        clear,
  output logic        car_present
);

  localparam int unsigned       STREAK_W    = 4;
  localparam logic [STREAK_W-1:0] CONFIRM_CNT = STREAK_W'(CONFIRM);
  // Far limit kept in 17 bits so CAR_THRESH+HYST never wraps.
  localparam logic [16:0]       FAR_LIMIT   = 17'(CAR_THRESH) + 17'(HYST);

  logic [STREAK_W-1:0] near_q, near_d;
  logic [STREAK_W-1:0] far_q, far_d;
  logic                car_q, car_d;
  logic                is_near, is_far;

  always_comb begin
    is_near = (sample < CAR_THRESH);
    is_far  = ({1'b0, sample} >= FAR_LIMIT);
    near_d  = near_q;
    far_d   = far_q;
    car_d   = car_q;
    if (clear) begin
      near_d = '0;
      far_d  = '0;
    end else if (sample_en) begin
      if (is_near) begin
        near_d = (near_q == CONFIRM_CNT) ? CONFIRM_CNT : near_q + STREAK_W'(1);
        far_d  = '0;
        if (near_d == CONFIRM_CNT) car_d = 1'b1;
      end else if (is_far) begin
        far_d  = (far_q == CONFIRM_CNT) ? CONFIRM_CNT : far_q + STREAK_W'(1);
        near_d = '0;
        if (far_d == CONFIRM_CNT) car_d = 1'b0;
      end else begin
        near_d = '0;
        far_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      near_q <= '0;
      far_q  <= '0;
      car_q  <= 1'b0;
    end else begin
      near_q <= near_d;
      far_q  <= far_d;
      car_q  <= car_d;
    end
  end

  assign car_present = car_q;

endmodule

// File: rtl/distance_poll_master.sv
// Bus initiator that periodically polls STATUS, then DISTANCE when valid, and
// feeds each valid reading into the car-presence hysteresis filter.
module distance_poll_master
  import distance_bus_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 5_000_000,
  parameter logic [15:0] CAR_THRESH  = 16'd200,
  parameter logic [15:0] HYST        = 16'd20,
  parameter int unsigned CONFIRM     = 3
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        enable,
  output logic [15:0] address,
  output logic        io_select,
  input  logic [15:0] read_data,
  output logic [15:0] dist_out,
  output logic        dist_valid,
  output logic        car_present,
  output logic [7:0]  miss_count
);

  localparam int unsigned         WAIT_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(POLL_CYCLES - 1);

  poll_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        miss_q, miss_d;
  logic [15:0]       dist_q, dist_d;
  logic [15:0]       addr_q, addr_d;
  logic              sel_q, sel_d;
  logic              valid_q, valid_d;

  // Next state, captures, and the registered bus/pulse outputs for the next cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    miss_d  = miss_q;
    dist_d  = dist_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RD_STAT;
        RD_STAT: begin
          if (read_data[STATUS_VALID_BIT]) begin
            state_d = RD_DIST;
          end else begin
            state_d = WAIT;
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
          end
        end
        RD_DIST: begin
          dist_d  = read_data;
          state_d = EVAL;
        end
        EVAL:    state_d = WAIT;
        WAIT: begin
          if (wait_q == WAIT_LAST) state_d = RD_STAT;
          else                     wait_d  = wait_q + WAIT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    sel_d   = (state_d == RD_STAT) || (state_d == RD_DIST);
    valid_d = (state_d == EVAL);
    case (state_d)
      RD_STAT: addr_d = STATUS;
      RD_DIST: addr_d = DISTANCE;
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      wait_q  <= '0;
      miss_q  <= '0;
      dist_q  <= '0;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      miss_q  <= miss_d;
      dist_q  <= dist_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  car_hysteresis_filter #(
    .CAR_THRESH (CAR_THRESH),
    .HYST       (HYST),
    .CONFIRM    (CONFIRM)
  ) u_filter (
    .clk         (clk),
    .reset_l     (reset_l),
    .sample      (dist_q),
    .sample_en   (state_q == EVAL),
    .clear       (!enable),
    .car_present (car_present)
  );

  assign address    = addr_q;
  assign io_select  = sel_q;
  assign dist_out   = dist_q;
  assign dist_valid = valid_q;
  assign miss_count = miss_q;

endmodule
